// File: rtl/nn_pkg.sv
//==============================================================================
// Module      : nn_pkg
// Description : Shared types and helpers for the output-layer classification.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package nn_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Index width for a vector of n elements; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage : nn_pkg

`default_nettype wire

// File: rtl/max_finder.sv
//==============================================================================
// Module      : max_finder
// Description : Captures a packed vector of neuron outputs and scans it one
//               element per clock, reporting the signed maximum and its index.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module max_finder
    import nn_pkg::*;
#(
    parameter  int numInput   = 10,
    parameter  int inputWidth = 16,
    localparam int idxWidth   = idx_width(numInput)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [numInput*inputWidth-1:0] i_data,
    input  logic                           i_valid,
    output logic                           i_ready,
    output logic [idxWidth-1:0]            o_index,
    output logic [inputWidth-1:0]          o_max,
    output logic                           o_valid
);

    localparam logic [idxWidth-1:0] c_LAST_IDX = idxWidth'(numInput - 1);

    if (numInput < 2) begin : g_param_check
        $error("max_finder: numInput must be at least 2");
    end

    state_t                        state_q;
    logic [idxWidth-1:0]           cnt_q;
    logic signed [inputWidth-1:0]  buf_q [numInput];
    logic signed [inputWidth-1:0]  run_max_q;
    logic [idxWidth-1:0]           run_idx_q;
    logic signed [inputWidth-1:0]  max_q;
    logic [idxWidth-1:0]           idx_q;
    logic                          valid_q;

    logic signed [inputWidth-1:0]  cand_d;
    logic                          take_d;
    logic signed [inputWidth-1:0]  max_d;
    logic [idxWidth-1:0]           idx_d;

    // Strict compare so that ties keep the earlier (lower) index.
    always_comb begin
        cand_d = buf_q[cnt_q];
        take_d = (cand_d > run_max_q);
        max_d  = take_d ? cand_d : run_max_q;
        idx_d  = take_d ? cnt_q  : run_idx_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            for (int k = 0; k < numInput; k++) begin
                buf_q[k] <= '0;
            end
            run_max_q <= '0;
            run_idx_q <= '0;
            max_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        for (int k = 0; k < numInput; k++) begin
                            buf_q[k] <= i_data[k*inputWidth +: inputWidth];
                        end
                        run_max_q <= i_data[inputWidth-1:0];
                        run_idx_q <= '0;
                        cnt_q     <= idxWidth'(1);
                        state_q   <= SCAN;
                    end
                end
                SCAN: begin
                    run_max_q <= max_d;
                    run_idx_q <= idx_d;
                    // The last compare folds straight into the published result.
                    if (cnt_q == c_LAST_IDX) begin
                        max_q   <= max_d;
                        idx_q   <= idx_d;
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q   <= cnt_q + idxWidth'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign i_ready = (state_q == IDLE);
    assign o_index = idx_q;
    assign o_max   = max_q;
    assign o_valid = valid_q;

endmodule : max_finder

`default_nettype wire

// File: tb/tb_max_finder.sv
//==============================================================================
// Module      : tb_max_finder
// Description : Table-driven, scoreboarded bench for max_finder.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_max_finder;

    localparam int N  = 10;
    localparam int W  = 16;
    localparam int IW = 4;

    typedef struct {
        logic [N*W-1:0] data;
        int             eidx;
        int             emax;
    } vec_t;

    typedef struct {
        int eidx;
        int emax;
        int cap_cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N*W-1:0] i_data = '0;
    logic           i_valid = 1'b0;
    logic           i_ready;
    logic [IW-1:0]  o_index;
    logic [W-1:0]   o_max;
    logic           o_valid;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   pulses   = 0;
    int   last_pulse = 0;
    int   prev_pulse = 0;
    logic prev_ov  = 1'b0;
    exp_t sb [$];
    vec_t tbl [5];

    max_finder #(.numInput(N), .inputWidth(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .o_index (o_index),
        .o_max   (o_max),
        .o_valid (o_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N*W-1:0] pk(input int v [N]);
        logic [N*W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*W +: W] = W'(v[k]);
        return r;
    endfunction

    // Scoreboard consumer: every pulse must match the oldest accepted vector.
    always @(negedge clk) begin
        if (rst) begin
            prev_ov <= 1'b0;
        end else begin
            if (o_valid) begin
                exp_t e;
                pulses++;
                prev_pulse = last_pulse;
                last_pulse = cyc;
                check("pulse_width_one_cycle", int'(prev_ov), 0);
                if (sb.size() == 0) begin
                    check("unexpected_o_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("o_index", int'(o_index), e.eidx);
                    check("o_max", int'($signed(o_max)), e.emax);
                    check("latency", cyc - e.cap_cyc, N - 1);
                end
            end
            prev_ov <= o_valid;
        end
    end

    // Presents a vector; returns after the accepting edge. hold keeps i_valid high.
    task automatic send(input logic [N*W-1:0] d, input int eidx, input int emax, input bit hold);
        int n;
        exp_t e;
        @(negedge clk);
        i_data  = d;
        i_valid = 1'b1;
        n = 0;
        while (!i_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("accept_timeout", 1, 0);
        end else begin
            e.eidx    = eidx;
            e.emax    = emax;
            e.cap_cyc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!hold) i_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_queue_empty", sb.size(), 0);
    endtask

    initial begin
        int v [N];
        int p0;

        for (int k = 0; k < N; k++) v[k] = k;
        tbl[0] = '{pk(v), 9, 9};
        v = '{100, 5, -3, 7, 0, 1, 2, 3, 4, 6};
        tbl[1] = '{pk(v), 0, 100};
        for (int k = 0; k < N; k++) v[k] = -5;
        v[7] = -1;
        tbl[2] = '{pk(v), 7, -1};
        for (int k = 0; k < N; k++) v[k] = 0;
        v[2] = 32767; v[6] = 32767;
        tbl[3] = '{pk(v), 2, 32767};
        for (int k = 0; k < N; k++) v[k] = -32768;
        v[9] = -32767;
        tbl[4] = '{pk(v), 9, -32767};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_o_valid", int'(o_valid), 0);
        check("rst_o_index", int'(o_index), 0);
        check("rst_o_max", int'(o_max), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_i_ready", int'(i_ready), 1);

        for (int t = 0; t < 5; t++) begin
            send(tbl[t].data, tbl[t].eidx, tbl[t].emax, 1'b0);
            drain();
        end
        check("pulse_count_table", pulses, 5);

        // Outputs hold the previous result after a new capture.
        v = '{1, 2, 3, 50, 4, 5, 6, 7, 8, 9};
        send(pk(v), 3, 50, 1'b0);
        @(negedge clk);
        check("hold_o_index", int'(o_index), 9);
        check("hold_o_max", int'($signed(o_max)), -32767);
        check("i_ready_low_in_scan", int'(i_ready), 0);
        drain();

        // Back-to-back with i_valid held high across the scan.
        v = '{0, 1, 2, 3, 1000, -7, 999, 4, 5, 6};
        send(tbl[1].data, 0, 100, 1'b1);
        send(pk(v), 4, 1000, 1'b0);
        drain();
        check("back_to_back_gap", last_pulse - prev_pulse, N);

        // Reset mid-scan aborts without a pulse and clears outputs.
        send(tbl[0].data, 9, 9, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        p0  = pulses;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("midscan_rst_o_valid", int'(o_valid), 0);
        check("midscan_rst_o_index", int'(o_index), 0);
        check("midscan_rst_o_max", int'(o_max), 0);
        rst = 1'b0;
        @(negedge clk);
        check("midscan_rel_i_ready", int'(i_ready), 1);
        repeat (15) @(negedge clk);
        check("midscan_no_pulse", pulses, p0);

        send(tbl[2].data, 7, -1, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_max_finder

`default_nettype wire

// File: doc/max_finder.md
Name: max_finder

Overview:
- Downstream classification stage of the output layer.
- Captures the parallel, packed outputs of the last layer's neurons in one handshake cycle, then scans them sequentially, one element per clock.
- Reports the index of the largest signed value (the predicted class) and the value itself.
- Sits after the final layer's output register; its result feeds the AXI/register readout.

Parameters:
- numInput, 10: number of neuron outputs compared; legal range ≥2.
- inputWidth, 16: width of each neuron output, signed two's complement.
- idxWidth, $clog2(numInput): width of the reported index (derived, not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_data  in  numInput*inputWidth  packed neuron outputs; element k = i_data[k*inputWidth +: inputWidth].
- i_valid  in  1  i_data valid this cycle.
- i_ready  out  1  block can accept i_data (high in IDLE).
- o_index  out  idxWidth  index of maximum element.
- o_max  out  inputWidth  value of maximum element.
- o_valid  out  1  one-cycle pulse; o_index/o_max valid.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, cnt=0, buffer=0, o_index=0, o_max=0, o_valid=0; i_ready=1 once rst deasserts.
  - rst asserted mid-scan aborts the scan with no o_valid pulse.
- States: IDLE, SCAN.
  - IDLE: i_ready=1. At an edge where i_valid=1:
    - latch all of i_data into the internal buffer;
    - running max = element 0, running idx = 0, cnt = 1;
    - go to SCAN.
  - SCAN: i_ready=0. Each edge:
    - compare buffer[cnt] against running max as signed; strictly greater → update max/idx;
    - cnt increments.
    - When cnt == numInput-1: register the final max/idx (including the result of this last compare) into o_max/o_index, assert o_valid for the following cycle, return to IDLE.
- Latency:
  - i_valid sampled at edge E0 → o_valid high in the cycle after edge E0+(numInput-1). For numInput=10 that is 9 edges after capture.
  - Throughput: one vector per numInput cycles, because a new vector is accepted in the same cycle o_valid is high.
- Handshake: i_valid while i_ready=0 is ignored. No buffering, no error flag; upstream must hold or re-present data.
- Ties: equal values keep the lower index (strict > compare).
- Outputs o_index/o_max hold their last result until the next completion. They are not cleared on new capture.
- Negative-only inputs: the signed compare must pick the least-negative value (e.g. all -5 except -1 at index 7 → index 7).
- Widths: comparisons at inputWidth signed; cnt width idxWidth, never wraps past numInput-1.

Decomposition:
- Shared package nn_pkg:
  - typedef enum logic {IDLE, SCAN} for the FSM state;
  - a localparam helper for the index width.
- Everything else stays in a single module; no sub-module warranted. The signed compare is one inline expression.

Test Plan:
- Ascending 0..9 presented once → o_valid exactly 9 cycles after capture, o_index=9, o_max=9, single-cycle pulse.
- Max at element 0: {100, 5, -3, 7, 0, 1, 2, 3, 4, 6} → o_index=0, o_max=100.
- Signed/ties:
  - all elements -5 except element 7 = -1 → o_index=7, o_max=-1;
  - elements 2 and 6 both 0x7FFF, rest 0 → o_index=2.
- Back-to-back: second vector (max at index 4) driven with i_valid held high continuously → ignored until i_ready; accepted in the o_valid cycle; second pulse exactly 10 cycles after the first with o_index=4.
- Reset mid-scan: assert rst 4 cycles after capture → o_valid never pulses, outputs 0, i_ready=1 after release; subsequent vector is processed correctly.
